// File: rtl/store_data_unit_pkg.sv
// Shared types for the store data path: store size encoding, control bus layout and FSM states.
package store_data_unit_pkg;

  typedef logic bool;

  typedef enum logic [1:0] {
    ST_DWORD = 2'b00,
    ST_WORD  = 2'b01,
    ST_BYTE  = 2'b10
  } store_size_mux_e;

  typedef struct packed {
    bool             store_en;
    store_size_mux_e store_size;
  } control_bus_t;

  localparam logic [2:0] NO_OP       = 3'b000;
  localparam logic [2:0] STORE_DWORD = {1'b1, ST_DWORD};
  localparam logic [2:0] STORE_WORD  = {1'b1, ST_WORD};
  localparam logic [2:0] STORE_BYTE  = {1'b1, ST_BYTE};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/store_data_unit_if.sv
// Data bus write port between the store unit (master) and the memory responder (slave).
interface store_data_unit_if;
  // Handshake: busWriteReq rises with address/data/byte enables already stable and holds them
  // until the slave raises busAck for one cycle (busError qualifies that ack) or the master times out.
  logic        busWriteReq;
  logic [31:0] busAddress;
  logic [31:0] busDataOut;
  logic [3:0]  busByteEn;
  logic        busAck;
  logic        busError;

  modport master (
    output busWriteReq, busAddress, busDataOut, busByteEn,
    input  busAck, busError
  );

  modport slave (
    input  busWriteReq, busAddress, busDataOut, busByteEn,
    output busAck, busError
  );
endinterface

// File: rtl/store_data_unit_lane_aligner.sv
// Combinational big-endian lane placement: replicates the store data, builds byte enables
// and flags addresses the selected size cannot reach.
module store_data_unit_lane_aligner
  import store_data_unit_pkg::*;
(
  input  logic [1:0]  store_size,
  input  logic [1:0]  offset,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [3:0]  byte_en,
  output logic        misaligned
);

  always_comb begin
    data_out   = '0;
    byte_en    = '0;
    misaligned = 1'b0;
    case (store_size)
      ST_BYTE: begin
        data_out = {4{data_in[7:0]}};
        case (offset)
          2'b00:   byte_en = 4'b1000;
          2'b01:   byte_en = 4'b0100;
          2'b10:   byte_en = 4'b0010;
          default: byte_en = 4'b0001;
        endcase
      end
      ST_WORD: begin
        data_out   = {2{data_in[15:0]}};
        byte_en    = offset[1] ? 4'b0011 : 4'b1100;
        misaligned = offset[0];
      end
      ST_DWORD: begin
        data_out   = data_in;
        byte_en    = 4'b1111;
        misaligned = |offset;
      end
      // Encoding 2'b11 is reserved and rejected like a misaligned access.
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_data_unit.sv
// Store unit: aligns B-register data onto the bus lanes and runs one write per store,
// reporting done, misalignment, bus error or timeout as single-cycle pulses.
module store_data_unit
  import store_data_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  control_bus_t        storeControl,
  input  logic                exceptionPending,
  input  logic [31:0]         storeAddress,
  input  logic [31:0]         storeData,
  output logic                busy,
  output logic                storeDone,
  output logic                alignFault,
  output logic                busFault,
  output logic                busTimeout,
  output logic [31:0]         faultAddress,
  store_data_unit_if.master   bus,
  output state_e              dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [31:0] lane_data;
  logic [3:0]  lane_be;
  logic        lane_misaligned;

  store_data_unit_lane_aligner u_aligner (
    .store_size (storeControl.store_size),
    .offset     (storeAddress[1:0]),
    .data_in    (storeData),
    .data_out   (lane_data),
    .byte_en    (lane_be),
    .misaligned (lane_misaligned)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [3:0]         be_q, be_d;
  logic               done_q, done_d;
  logic               align_q, align_d;
  logic               bfault_q, bfault_d;
  logic               tout_q, tout_d;
  logic [31:0]        fault_addr_q, fault_addr_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    addr_d       = addr_q;
    data_d       = data_q;
    be_d         = be_q;
    done_d       = 1'b0;
    align_d      = 1'b0;
    bfault_d     = 1'b0;
    tout_d       = 1'b0;
    fault_addr_d = fault_addr_q;
    case (state_q)
      S_IDLE: begin
        if (storeControl.store_en && !exceptionPending) begin
          if (lane_misaligned) begin
            align_d      = 1'b1;
            fault_addr_d = storeAddress;
          end else begin
            // Full byte address is kept so a later fault reports what the core asked for.
            addr_d  = storeAddress;
            data_d  = lane_data;
            be_d    = lane_be;
            cnt_d   = '0;
            req_d   = 1'b1;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (bus.busAck) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
          if (bus.busError) begin
            bfault_d     = 1'b1;
            fault_addr_d = addr_q;
          end else begin
            done_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d        = 1'b0;
          state_d      = S_IDLE;
          tout_d       = 1'b1;
          fault_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      be_q         <= '0;
      done_q       <= 1'b0;
      align_q      <= 1'b0;
      bfault_q     <= 1'b0;
      tout_q       <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      be_q         <= be_d;
      done_q       <= done_d;
      align_q      <= align_d;
      bfault_q     <= bfault_d;
      tout_q       <= tout_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign busy            = (state_q == S_WRITE);
  assign storeDone       = done_q;
  assign alignFault      = align_q;
  assign busFault        = bfault_q;
  assign busTimeout      = tout_q;
  assign faultAddress    = fault_addr_q;
  assign dbg_state       = state_q;
  assign bus.busWriteReq = req_q;
  assign bus.busAddress  = {addr_q[31:2], 2'b00};
  assign bus.busDataOut  = data_q;
  assign bus.busByteEn   = be_q;

endmodule
